// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, runs a valid/data_ok bus
// access for loads and stores, and aligns/extends load data for writeback.
module mem_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_sdata,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              in_regwrite,
    input  logic              in_memread,
    input  logic              in_memwrite,
    input  logic [2:0]        in_funct3,
    output logic              dreq_valid,
    output logic [XLEN-1:0]   dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_regwrite,
    output logic [XLEN-1:0]   out_data,
    output logic              out_misalign,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_dst,
    output logic [XLEN-1:0]   fwd_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0]   stage_pc;
    logic [XLEN-1:0]   stage_alu;
    logic [XLEN-1:0]   stage_sdata;
    logic [XLEN-1:0]   stage_data;
    logic [REG_AW-1:0] stage_dst;
    logic              stage_regwrite;
    logic              stage_memread;
    logic              stage_memwrite;
    logic [2:0]        stage_funct3;
    logic              stage_misalign;

    logic              accept;
    logic              in_mem;
    logic              in_misalign;
    logic [XLEN-1:0]   load_shifted;
    logic [XLEN-1:0]   load_ext;
    logic              load_sign;
    logic [7:0]        strobe_base;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign in_mem   = in_memread || in_memwrite;

    always_comb begin
        in_misalign = 1'b0;
        case (in_funct3[1:0])
            2'd0: in_misalign = 1'b0;
            2'd1: in_misalign = in_alu[0];
            2'd2: in_misalign = |in_alu[1:0];
            2'd3: in_misalign = |in_alu[2:0];
            default: in_misalign = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (in_mem && !in_misalign) ? ACCESS : DONE;
            end
            ACCESS: begin
                if (dresp_data_ok) state_nxt = DONE;
            end
            DONE: begin
                if (accept) state_nxt = (in_mem && !in_misalign) ? ACCESS : DONE;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load data: move the addressed lane to bit 0, then sign/zero extend by size.
    assign load_shifted = dresp_data >> {stage_alu[2:0], 3'b000};
    assign load_sign    = ~stage_funct3[2];

    always_comb begin
        load_ext = load_shifted;
        case (stage_funct3[1:0])
            2'd0: load_ext = {{(XLEN-8){load_sign & load_shifted[7]}}, load_shifted[7:0]};
            2'd1: load_ext = {{(XLEN-16){load_sign & load_shifted[15]}}, load_shifted[15:0]};
            2'd2: load_ext = {{(XLEN-32){load_sign & load_shifted[31]}}, load_shifted[31:0]};
            default: load_ext = load_shifted;
        endcase
    end

    always_comb begin
        strobe_base = 8'h00;
        case (stage_funct3[1:0])
            2'd0: strobe_base = 8'h01;
            2'd1: strobe_base = 8'h03;
            2'd2: strobe_base = 8'h0F;
            default: strobe_base = 8'hFF;
        endcase
    end

    // Misalignment is resolved at capture so the DONE record is already final.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_pc       <= '0;
            stage_alu      <= '0;
            stage_sdata    <= '0;
            stage_data     <= '0;
            stage_dst      <= '0;
            stage_regwrite <= 1'b0;
            stage_memread  <= 1'b0;
            stage_memwrite <= 1'b0;
            stage_funct3   <= '0;
            stage_misalign <= 1'b0;
        end else if (accept) begin
            stage_pc       <= in_pc;
            stage_alu      <= in_alu;
            stage_sdata    <= in_sdata;
            stage_data     <= in_alu;
            stage_dst      <= in_dst;
            stage_regwrite <= in_regwrite && !(in_mem && in_misalign);
            stage_memread  <= in_memread;
            stage_memwrite <= in_memwrite;
            stage_funct3   <= in_funct3;
            stage_misalign <= in_mem && in_misalign;
        end else if (state == ACCESS && dresp_data_ok) begin
            stage_data <= stage_memread ? load_ext : stage_alu;
        end
    end

    assign dreq_valid  = (state == ACCESS);
    assign dreq_addr   = dreq_valid ? stage_alu : '0;
    assign dreq_size   = dreq_valid ? {1'b0, stage_funct3[1:0]} : 3'd0;
    assign dreq_strobe = (dreq_valid && stage_memwrite) ? (strobe_base << stage_alu[2:0]) : 8'h00;
    assign dreq_data   = (dreq_valid && stage_memwrite) ? (stage_sdata << {stage_alu[2:0], 3'b000}) : '0;

    assign out_valid    = (state == DONE);
    assign out_pc       = stage_pc;
    assign out_dst      = stage_dst;
    assign out_regwrite = stage_regwrite;
    assign out_data     = stage_data;
    assign out_misalign = stage_misalign;

    assign fwd_valid = (state == DONE) && stage_regwrite && (stage_dst != '0);
    assign fwd_dst   = stage_dst;
    assign fwd_data  = stage_data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_alu;
    logic [XLEN-1:0]   in_sdata;
    logic [REG_AW-1:0] in_dst;
    logic              in_regwrite;
    logic              in_memread;
    logic              in_memwrite;
    logic [2:0]        in_funct3;
    logic              dreq_valid;
    logic [XLEN-1:0]   dreq_addr;
    logic [2:0]        dreq_size;
    logic [7:0]        dreq_strobe;
    logic [XLEN-1:0]   dreq_data;
    logic              dresp_data_ok;
    logic [XLEN-1:0]   dresp_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [REG_AW-1:0] out_dst;
    logic              out_regwrite;
    logic [XLEN-1:0]   out_data;
    logic              out_misalign;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_dst;
    logic [XLEN-1:0]   fwd_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu(in_alu),
        .in_sdata(in_sdata), .in_dst(in_dst), .in_regwrite(in_regwrite),
        .in_memread(in_memread), .in_memwrite(in_memwrite), .in_funct3(in_funct3),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_dst(out_dst), .out_regwrite(out_regwrite), .out_data(out_data),
        .out_misalign(out_misalign),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [63:0] alu, input logic [63:0] sdata, input logic [4:0] dst,
                          input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
        in_valid    = 1'b1;
        in_pc       = alu + 64'h4000_0000;
        in_alu      = alu;
        in_sdata    = sdata;
        in_dst      = dst;
        in_regwrite = rw;
        in_memread  = mr;
        in_memwrite = mw;
        in_funct3   = f3;
    endtask

    // Aligned load with a fixed number of wait cycles before data_ok.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp);
        out_ready = 1'b1;
        set_op(addr, 64'h0, 5'd7, 1'b1, 1'b1, 1'b0, f3);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, " dreq_valid"}, {63'd0, dreq_valid}, 64'd1);
            check({tag, " in_ready"}, {63'd0, in_ready}, 64'd0);
            check({tag, " fwd_valid"}, {63'd0, fwd_valid}, 64'd0);
            if (i == 2) begin
                dresp_data_ok = 1'b1;
                dresp_data    = rdata;
            end
            tick();
        end
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        check({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, " out_data"}, out_data, exp);
        check({tag, " fwd_valid"}, {63'd0, fwd_valid}, 64'd1);
        check({tag, " fwd_data"}, fwd_data, exp);
        tick();
        check({tag, " idle"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_pc         = '0;
        in_alu        = '0;
        in_sdata      = '0;
        in_dst        = '0;
        in_regwrite   = 1'b0;
        in_memread    = 1'b0;
        in_memwrite   = 1'b0;
        in_funct3     = '0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        out_ready     = 1'b0;
        #1;
        check("rst in_ready", {63'd0, in_ready}, 64'd1);
        check("rst out_valid", {63'd0, out_valid}, 64'd0);
        check("rst dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("rst fwd_valid", {63'd0, fwd_valid}, 64'd0);
        check("rst out_data", out_data, 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // ALU op then back-to-back second op
        out_ready = 1'b1;
        set_op(64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b011);
        check("alu in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("alu out_valid", {63'd0, out_valid}, 64'd1);
        check("alu out_data", out_data, 64'h1234);
        check("alu out_pc", out_pc, 64'h4000_1234);
        check("alu fwd_valid", {63'd0, fwd_valid}, 64'd1);
        check("alu fwd_dst", {59'd0, fwd_dst}, 64'd5);
        check("alu b2b in_ready", {63'd0, in_ready}, 64'd1);
        set_op(64'h55, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        check("b2b out_valid", {63'd0, out_valid}, 64'd1);
        check("b2b out_data", out_data, 64'h55);
        check("b2b dst0 fwd_valid", {63'd0, fwd_valid}, 64'd0);
        in_valid = 1'b0;
        tick();
        check("b2b idle", {63'd0, out_valid}, 64'd0);

        // Loads: sign/zero extension and lane selection
        do_load("lb", 3'b000, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 3'b100, 64'h1003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        do_load("lh", 3'b001, 64'h1002, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D);
        do_load("lhu", 3'b101, 64'h1002, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D);
        do_load("lw", 3'b010, 64'h1004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        do_load("lwu", 3'b110, 64'h1004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        do_load("ld", 3'b011, 64'h1008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        // Store halfword at lane 6
        set_op(64'h1006, 64'hBEEF, 5'd9, 1'b0, 1'b0, 1'b1, 3'b001);
        tick();
        in_valid = 1'b0;
        check("sh dreq_valid", {63'd0, dreq_valid}, 64'd1);
        check("sh dreq_addr", dreq_addr, 64'h1006);
        check("sh dreq_size", {61'd0, dreq_size}, 64'd1);
        check("sh dreq_strobe", {56'd0, dreq_strobe}, 64'hC0);
        check("sh dreq_data", dreq_data, 64'hBEEF_0000_0000_0000);
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        check("sh out_valid", {63'd0, out_valid}, 64'd1);
        check("sh out_regwrite", {63'd0, out_regwrite}, 64'd0);
        check("sh fwd_valid", {63'd0, fwd_valid}, 64'd0);
        check("sh out_data", out_data, 64'h1006);
        tick();

        // Store word at lane 4
        set_op(64'h2004, 64'h1122_3344, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
        tick();
        in_valid = 1'b0;
        check("sw dreq_strobe", {56'd0, dreq_strobe}, 64'hF0);
        check("sw dreq_data", dreq_data, 64'h1122_3344_0000_0000);
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        tick();

        // Misaligned lw: no bus request, straight to DONE
        set_op(64'h1002, 64'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
        tick();
        in_valid = 1'b0;
        check("mis dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("mis out_valid", {63'd0, out_valid}, 64'd1);
        check("mis out_misalign", {63'd0, out_misalign}, 64'd1);
        check("mis out_regwrite", {63'd0, out_regwrite}, 64'd0);
        check("mis fwd_valid", {63'd0, fwd_valid}, 64'd0);
        check("mis out_data", out_data, 64'h1002);
        tick();

        // Backpressure in DONE, then accept as out_ready rises
        out_ready = 1'b0;
        set_op(64'hAA, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        set_op(64'hBB, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            check("bp out_valid", {63'd0, out_valid}, 64'd1);
            check("bp out_data", out_data, 64'hAA);
            check("bp out_dst", {59'd0, out_dst}, 64'd3);
            check("bp in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp new out_data", out_data, 64'hBB);
        check("bp new out_dst", {59'd0, out_dst}, 64'd4);
        check("bp new out_misalign", {63'd0, out_misalign}, 64'd0);
        tick();

        // Reset during ACCESS, then a stale data_ok
        set_op(64'h3000, 64'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b011);
        tick();
        in_valid = 1'b0;
        check("rstacc dreq_valid before", {63'd0, dreq_valid}, 64'd1);
        reset = 1'b1;
        #1;
        check("rstacc dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("rstacc in_ready", {63'd0, in_ready}, 64'd1);
        check("rstacc out_valid", {63'd0, out_valid}, 64'd0);
        #2;
        reset = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hDEAD_BEEF;
        tick();
        dresp_data_ok = 1'b0;
        check("rstacc late out_valid", {63'd0, out_valid}, 64'd0);
        check("rstacc late in_ready", {63'd0, in_ready}, 64'd1);
        check("rstacc late dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("rstacc late out_data", out_data, 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
